oh_field_decoder: RTL and testbench
===================================

Name: oh_field_decoder

Overview:
- Decode-stage producer for the operand handler's immediate/select interface.
- Accepts fetched 32-bit PA-RISC instruction words over a valid/ready handshake, and classifies the 6-bit major opcode.
- Emits, registered, the 3-bit operand select `oh_s`, the 21-bit immediate field `oh_i` (assembled where the ISA scrambles it) and register specifiers.
- A 2-entry skid buffer decouples upstream fetch from downstream execute stalls.

Parameters:
- `SKID_DEPTH`, 2, number of buffered entries (fixed at 2; other values unsupported).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous discard of all buffered and output entries.
- `in_valid`  in  1  instruction word valid.
- `in_ready`  out  1  decoder can accept.
- `in_instr`  in  32  instruction word, bit 31 = MSB (opcode in [31:26]).
- `out_valid`  out  1  decoded entry valid.
- `out_ready`  in  1  execute stage accepts.
- `oh_s`  out  3  operand-handler select.
- `oh_i`  out  21  operand-handler immediate field.
- `rb`  out  5  base/source register specifier, `in_instr[25:21]`.
- `rr`  out  5  second source register, `in_instr[20:16]`.
- `rt`  out  5  target: `in_instr[4:0]` for opcode 0x02, else `in_instr[20:16]`.
- `illegal`  out  1  opcode not recognised.
- `trap`  out  1  sticky illegal trap (feature only, else tied 0).
- `trap_clear`  in  1  clears trap (feature only, else ignored).

Behaviour:
- Reset (async, `reset_n`=0): `out_valid`=0, `in_ready`=0 while asserted then 1, `oh_s`=3'b111, `oh_i`=0, `rb`/`rr`/`rt`=0, `illegal`=0, `trap`=0, skid empty.
- Decode table (opcode=`in_instr[31:26]`):
  - 0x02 → S=000 (RB).
  - 0x24, 0x25, 0x2C, 0x2D → S=001 (im11).
  - 0x0D, 0x10, 0x11, 0x12, 0x18, 0x19, 0x1A → S=010 (im14).
  - 0x08, 0x0A → S=011 (im21).
  - 0x34 with `[12:10]`=110 → S=100; 0x34 with `[12:10]`=111 → S=101.
  - 0x35 with `[12:10]`=010 → S=110.
  - All others → S=111, `illegal`=1.
- `oh_i`:
  - S=011: assemble_21, i.e. `I[20]=w[0]`, `I[19:9]=w[11:1]`, `I[8:7]=w[15:14]`, `I[6:2]=w[20:16]`, `I[1:0]=w[13:12]`.
  - Otherwise `oh_i = in_instr[20:0]` unmodified. Sign/low-sign handling and the `31-pos` shift conversion stay in the operand handler.
- Handshake:
  - A transfer occurs on `valid && ready` at a rising edge.
  - Latency is 1 cycle from input acceptance to `out_valid`.
  - Once `out_valid`=1, the outputs are held stable until `out_ready`=1.
- Skid buffer:
  - `in_ready` is registered: `in_ready`=1 iff skid occupancy < 2.
  - An entry accepted while the output register is stalled goes to the skid; the skid drains in FIFO order.
  - With occupancy 2, `in_ready`=0 and input is ignored.
  - Simultaneous accept and drain keeps occupancy unchanged.
  - With the skid empty and `out_ready`=1, throughput is 1 per cycle.
- `flush`:
  - Next edge: `out_valid`=0, skid emptied, `in_ready`=1.
  - An input presented in the `flush` cycle is dropped.
  - `flush` has priority over every other event.
- Reset mid-transfer: all entries are lost; no partial output.

Optional Feature:
- Macro `OH_DECODE_ILLEGAL_TRAP_EN`.
- Defined:
  - An illegal entry reaching the output register sets `trap`=1 (sticky).
  - From then on `in_ready`=0 and `out_valid`=0 until a `trap_clear` pulse; the trapping entry is discarded.
  - `trap_clear` and `flush` in the same cycle: both take effect.
- Undefined: illegal entries pass through with S=111, `illegal`=1; `trap` is tied 0.

Decomposition:
- Package `oh_pkg`:
  - S encoding constants `OH_S_RB`…`OH_S_ZERO` (000–111).
  - Opcode constants.
  - A decoded-entry struct `{s, i, rb, rr, rt, illegal}`.
- Sub-module `oh_field_decode`: purely combinational instr → entry, shared by the input and skid paths.
- The top holds the skid FIFO, output register and trap state.

Test Plan:
- LDO `in_instr`=0x34640005, `out_ready`=1 → next cycle `oh_s`=010, `oh_i`=0x040005, `rb`=3, `rt`=4, `illegal`=0.
- LDIL `in_instr`=0x20000001 → `oh_s`=011, `oh_i`=0x100000; LDIL `in_instr`=0x20003000 → `oh_i`=0x000003.
- Hold `out_ready`=0 and push 3 words back-to-back → first held at the output, 2 in skid, `in_ready`=0 after the 3rd. Release → outputs emerge in order on 3 consecutive cycles.
- Opcode 0x3F (`in_instr`=0xFC000000) → `oh_s`=111, `illegal`=1. With the macro: `trap`=1 and `in_ready`=0 until `trap_clear`.
- Fill the skid, then assert `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, no stale entry ever appears.
- Assert `reset_n`=0 asynchronously mid-stall → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/oh_pkg.sv
// Shared types and constants for the operand-handler field decoder.
package oh_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned S_W     = 3;
  localparam int unsigned IMM_W   = 21;
  localparam int unsigned REG_W   = 5;

  // Operand-handler select encodings
  localparam logic [S_W-1:0] OH_S_RB      = 3'b000;
  localparam logic [S_W-1:0] OH_S_IM11    = 3'b001;
  localparam logic [S_W-1:0] OH_S_IM14    = 3'b010;
  localparam logic [S_W-1:0] OH_S_IM21    = 3'b011;
  localparam logic [S_W-1:0] OH_S_SHIFT_A = 3'b100;
  localparam logic [S_W-1:0] OH_S_SHIFT_B = 3'b101;
  localparam logic [S_W-1:0] OH_S_SHIFT_C = 3'b110;
  localparam logic [S_W-1:0] OH_S_ZERO    = 3'b111;

  // Major opcodes recognised by the decoder
  localparam logic [OP_W-1:0] OP_ALU     = 6'h02;
  localparam logic [OP_W-1:0] OP_LDIL    = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIL   = 6'h0A;
  localparam logic [OP_W-1:0] OP_LDO     = 6'h0D;
  localparam logic [OP_W-1:0] OP_LDB     = 6'h10;
  localparam logic [OP_W-1:0] OP_LDH     = 6'h11;
  localparam logic [OP_W-1:0] OP_LDW     = 6'h12;
  localparam logic [OP_W-1:0] OP_STB     = 6'h18;
  localparam logic [OP_W-1:0] OP_STH     = 6'h19;
  localparam logic [OP_W-1:0] OP_STW     = 6'h1A;
  localparam logic [OP_W-1:0] OP_COMICLR = 6'h24;
  localparam logic [OP_W-1:0] OP_SUBI    = 6'h25;
  localparam logic [OP_W-1:0] OP_ADDIT   = 6'h2C;
  localparam logic [OP_W-1:0] OP_ADDI    = 6'h2D;
  localparam logic [OP_W-1:0] OP_EXTRACT = 6'h34;
  localparam logic [OP_W-1:0] OP_DEPOSIT = 6'h35;

  // One decoded instruction as presented to the operand handler
  typedef struct packed {
    logic [S_W-1:0]   s;
    logic [IMM_W-1:0] i;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rr;
    logic [REG_W-1:0] rt;
    logic             illegal;
  } oh_entry_t;

  localparam oh_entry_t OH_ENTRY_RESET = '{s: OH_S_ZERO, i: '0, rb: '0, rr: '0, rt: '0, illegal: 1'b0};

  // Unscramble the 21-bit long immediate of LDIL/ADDIL
  function automatic logic [IMM_W-1:0] assemble_21(input logic [INSTR_W-1:0] w);
    return {w[0], w[11:1], w[15:14], w[20:16], w[13:12]};
  endfunction

endpackage

// File: rtl/oh_field_decode.sv
// Combinational instruction word -> decoded operand-handler entry.
module oh_field_decode
  import oh_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output oh_entry_t          entry
);

  logic [OP_W-1:0] op;
  logic [2:0]      sub;

  assign op  = instr[31:26];
  assign sub = instr[12:10];

  // Classify the major opcode and pick the immediate form
  always_comb begin
    entry = OH_ENTRY_RESET;
    case (op)
      OP_ALU:                                   entry.s = OH_S_RB;
      OP_COMICLR, OP_SUBI, OP_ADDIT, OP_ADDI:   entry.s = OH_S_IM11;
      OP_LDO, OP_LDB, OP_LDH, OP_LDW,
      OP_STB, OP_STH, OP_STW:                   entry.s = OH_S_IM14;
      OP_LDIL, OP_ADDIL:                        entry.s = OH_S_IM21;
      OP_EXTRACT: begin
        if (sub == 3'b110)      entry.s = OH_S_SHIFT_A;
        else if (sub == 3'b111) entry.s = OH_S_SHIFT_B;
        else                    entry.s = OH_S_ZERO;
      end
      OP_DEPOSIT:                               entry.s = (sub == 3'b010) ? OH_S_SHIFT_C : OH_S_ZERO;
      default:                                  entry.s = OH_S_ZERO;
    endcase
    entry.illegal = (entry.s == OH_S_ZERO);
    entry.i       = (entry.s == OH_S_IM21) ? assemble_21(instr) : instr[IMM_W-1:0];
    entry.rb      = instr[25:21];
    entry.rr      = instr[20:16];
    entry.rt      = (op == OP_ALU) ? instr[4:0] : instr[20:16];
  end

endmodule

// File: rtl/oh_field_decoder.sv
// Decode stage: valid/ready input, 2-entry skid of raw words, registered
// decoded output. Optional sticky illegal trap under OH_DECODE_ILLEGAL_TRAP_EN.
module oh_field_decoder
  import oh_pkg::*;
#(
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [S_W-1:0]      oh_s,
  output logic [IMM_W-1:0]    oh_i,
  output logic [REG_W-1:0]    rb,
  output logic [REG_W-1:0]    rr,
  output logic [REG_W-1:0]    rt,
  output logic                illegal,
  output logic                trap,
  input  logic                trap_clear
);

  localparam int unsigned CNT_W = 2;

  oh_entry_t          in_ent, sk_ent, ld_ent;
  oh_entry_t          out_q, out_d;
  logic               ov_q, ov_d;
  logic               rdy_q, rdy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] sk_q [2];
  logic [INSTR_W-1:0] sk_d [2];
  logic               in_fire, adv, pop, push, ld_en;
  logic               trap_q, trap_d;

  oh_field_decode u_dec_in (.instr(in_instr), .entry(in_ent));
  oh_field_decode u_dec_sk (.instr(sk_q[0]),  .entry(sk_ent));

  // Next-state: output register advance, skid push/pop, flush, trap
  always_comb begin
    ov_d    = ov_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    sk_d    = sk_q;
    trap_d  = trap_q;
    pop     = 1'b0;
    push    = 1'b0;
    ld_en   = 1'b0;
    ld_ent  = in_ent;
    in_fire = in_valid && rdy_q;
    adv     = (!ov_q || out_ready) && !trap_q;

    if (adv) begin
      if (cnt_q != '0) begin
        ld_ent = sk_ent;
        ld_en  = 1'b1;
        pop    = 1'b1;
        push   = in_fire;
      end else if (in_fire) begin
        ld_en  = 1'b1;
      end else begin
        ov_d   = 1'b0;
      end
    end else begin
      push = in_fire;
    end

    if (ld_en) begin
`ifdef OH_DECODE_ILLEGAL_TRAP_EN
      if (ld_ent.illegal) begin
        trap_d = 1'b1;
        ov_d   = 1'b0;
      end else begin
        ov_d   = 1'b1;
        out_d  = ld_ent;
      end
`else
      ov_d  = 1'b1;
      out_d = ld_ent;
`endif
    end

    if (pop) sk_d[0] = sk_q[1];
    if (push) begin
      if ((cnt_q - CNT_W'(pop)) == '0) sk_d[0] = in_instr;
      else                             sk_d[1] = in_instr;
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

`ifdef OH_DECODE_ILLEGAL_TRAP_EN
    if (trap_clear) trap_d = 1'b0;
`endif

    if (flush) begin
      ov_d  = 1'b0;
      cnt_d = '0;
    end

    rdy_d = (cnt_d < CNT_W'(SKID_DEPTH)) && !trap_d;
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ov_q     <= 1'b0;
      out_q    <= OH_ENTRY_RESET;
      rdy_q    <= 1'b0;
      cnt_q    <= '0;
      sk_q[0]  <= '0;
      sk_q[1]  <= '0;
    end else begin
      ov_q     <= ov_d;
      out_q    <= out_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
      sk_q     <= sk_d;
    end
  end

`ifdef OH_DECODE_ILLEGAL_TRAP_EN
  // Sticky trap flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trap_q <= 1'b0;
    else          trap_q <= trap_d;
  end
  assign trap = trap_q;
`else
  logic unused_trap_clear;
  assign trap_q            = 1'b0;
  assign trap              = 1'b0;
  assign unused_trap_clear = trap_clear;
`endif

  assign in_ready  = rdy_q;
  assign out_valid = ov_q;
  assign oh_s      = out_q.s;
  assign oh_i      = out_q.i;
  assign rb        = out_q.rb;
  assign rr        = out_q.rr;
  assign rt        = out_q.rt;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_oh_field_decoder.sv
// Randomized self-checking bench for oh_field_decoder against a queue model.
module tb_oh_field_decoder;

  logic        clk, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  oh_s;
  logic [20:0] oh_i;
  logic [4:0]  rb, rr, rt;
  logic        illegal, trap, trap_clear;

  oh_field_decoder dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .oh_s(oh_s), .oh_i(oh_i), .rb(rb), .rr(rr), .rt(rt),
    .illegal(illegal), .trap(trap), .trap_clear(trap_clear)
  );

  typedef struct {
    int unsigned s, i, rb, rr, rt, ill;
  } exp_t;

  exp_t q[$];
  bit   rdy_m;
  int   n_chk = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written from the opcode table
  function automatic exp_t ref_dec(input int unsigned w);
    exp_t e;
    int unsigned op, sub;
    op  = (w >> 26) & 32'h3F;
    sub = (w >> 10) & 32'h7;
    e.s = 7;
    if (op == 32'h02) e.s = 0;
    else if (op == 32'h24 || op == 32'h25 || op == 32'h2C || op == 32'h2D) e.s = 1;
    else if (op == 32'h0D || op == 32'h10 || op == 32'h11 || op == 32'h12 ||
             op == 32'h18 || op == 32'h19 || op == 32'h1A) e.s = 2;
    else if (op == 32'h08 || op == 32'h0A) e.s = 3;
    else if (op == 32'h34 && sub == 6) e.s = 4;
    else if (op == 32'h34 && sub == 7) e.s = 5;
    else if (op == 32'h35 && sub == 2) e.s = 6;
    e.ill = (e.s == 7) ? 1 : 0;
    if (e.s == 3)
      e.i = (w & 1) * 1048576 + ((w >> 1) & 32'h7FF) * 512 + ((w >> 14) & 3) * 128
          + ((w >> 16) & 32'h1F) * 4 + ((w >> 12) & 3);
    else
      e.i = w % 2097152;
    e.rb = (w >> 21) & 31;
    e.rr = (w >> 16) & 31;
    e.rt = (op == 32'h02) ? (w & 31) : e.rr;
    return e;
  endfunction

  task automatic check_outputs(input string ph);
    chk({ph, ".out_valid"}, 32'(out_valid), (q.size() > 0) ? 1 : 0);
    chk({ph, ".in_ready"},  32'(in_ready),  32'(rdy_m));
    chk({ph, ".trap"},      32'(trap), 0);
    if (q.size() > 0) begin
      chk({ph, ".oh_s"},    32'(oh_s),    q[0].s);
      chk({ph, ".oh_i"},    32'(oh_i),    q[0].i);
      chk({ph, ".rb"},      32'(rb),      q[0].rb);
      chk({ph, ".rr"},      32'(rr),      q[0].rr);
      chk({ph, ".rt"},      32'(rt),      q[0].rt);
      chk({ph, ".illegal"}, 32'(illegal), q[0].ill);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic cycle(input string ph, input logic v, input logic [31:0] w,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && rdy_m) q.push_back(ref_dec(w));
    end
    rdy_m = (q.size() < 3);
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic check_reset_values(input string ph);
    chk({ph, ".out_valid"}, 32'(out_valid), 0);
    chk({ph, ".in_ready"},  32'(in_ready), 0);
    chk({ph, ".oh_s"},      32'(oh_s), 7);
    chk({ph, ".oh_i"},      32'(oh_i), 0);
    chk({ph, ".rb"},        32'(rb), 0);
    chk({ph, ".rr"},        32'(rr), 0);
    chk({ph, ".rt"},        32'(rt), 0);
    chk({ph, ".illegal"},   32'(illegal), 0);
    chk({ph, ".trap"},      32'(trap), 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  op;
    int unsigned pick;
    logic [5:0]  ops [16];
    ops = '{6'h02, 6'h24, 6'h25, 6'h2C, 6'h2D, 6'h0D, 6'h10, 6'h11,
            6'h12, 6'h18, 6'h19, 6'h1A, 6'h08, 6'h0A, 6'h34, 6'h35};
    w    = $urandom;
    pick = $urandom_range(0, 19);
    op   = (pick < 16) ? ops[pick] : w[31:26];
    w[31:26] = op;
    if ($urandom_range(0, 1) == 1) begin
      case ($urandom_range(0, 2))
        0:       w[12:10] = 3'b110;
        1:       w[12:10] = 3'b111;
        default: w[12:10] = 3'b010;
      endcase
    end
    return w;
  endfunction

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; trap_clear = 1'b0;
    rdy_m = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    cycle("post_reset", 1'b0, 32'h0, 1'b1, 1'b0);

    // LDO
    cycle("ldo", 1'b1, 32'h34640005, 1'b1, 1'b0);
    chk("ldo_s", 32'(oh_s), 32'h2);
    chk("ldo_i", 32'(oh_i), 32'h040005);
    chk("ldo_rb", 32'(rb), 3);
    chk("ldo_rt", 32'(rt), 4);
    chk("ldo_ill", 32'(illegal), 0);

    // LDIL immediate scrambling
    cycle("ldil1", 1'b1, 32'h20000001, 1'b1, 1'b0);
    chk("ldil1_s", 32'(oh_s), 32'h3);
    chk("ldil1_i", 32'(oh_i), 32'h100000);
    cycle("ldil2", 1'b1, 32'h20003000, 1'b1, 1'b0);
    chk("ldil2_i", 32'(oh_i), 32'h000003);

    // Illegal opcode passes through
    cycle("illop", 1'b1, 32'hFC000000, 1'b1, 1'b0);
    chk("illop_s", 32'(oh_s), 32'h7);
    chk("illop_ill", 32'(illegal), 1);
    cycle("drain0", 1'b0, 32'h0, 1'b1, 1'b0);

    // Stall with three back-to-back pushes, then release
    cycle("stall1", 1'b1, 32'h08210000, 1'b0, 1'b0);
    cycle("stall2", 1'b1, 32'h344A0000, 1'b0, 1'b0);
    cycle("stall3", 1'b1, 32'h08660000, 1'b0, 1'b0);
    chk("stall_rdy", 32'(in_ready), 0);
    chk("stall_head_rb", 32'(rb), 1);
    cycle("stall4", 1'b1, 32'h0BE00000, 1'b0, 1'b0);
    cycle("rel1", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rel1_rb", 32'(rb), 2);
    cycle("rel2", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rel2_rb", 32'(rb), 3);
    cycle("rel3", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rel3_valid", 32'(out_valid), 0);

    // Fill, then flush with a concurrent input
    cycle("ffill1", 1'b1, 32'h34200000, 1'b0, 1'b0);
    cycle("ffill2", 1'b1, 32'h34400000, 1'b0, 1'b0);
    cycle("ffill3", 1'b1, 32'h34600000, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'h34800000, 1'b0, 1'b1);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_rdy", 32'(in_ready), 1);
    repeat (3) cycle("postflush", 1'b0, 32'h0, 1'b1, 1'b0);

    // Async reset mid-stall
    cycle("ar1", 1'b1, 32'h34200000, 1'b0, 1'b0);
    cycle("ar2", 1'b1, 32'h34400000, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    q.delete();
    rdy_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle("ar_release", 1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle("rand", ($urandom_range(0, 9) < 7), rand_instr(),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
